// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers for the MIPS EX stage.
// The full result is computed at start; Busy holds off the pipeline for a fixed latency.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  MDUOp,
    output logic [31:0] MDUResult,
    output logic        Busy
);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic        [31:0] b_nz, quot_u, rem_u;
    logic               div_zero, div_ovf;

    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        b_nz     = div_zero ? 32'd1 : B;
        a_s      = $signed(A);
        // Dividing the most negative value by 1 gives the architected overflow result
        b_s      = div_ovf ? 32'sd1 : $signed(b_nz);
        quot_s   = a_s / b_s;
        rem_s    = a_s % b_s;
        quot_u   = A / b_nz;
        rem_u    = A % b_nz;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            case (MDUOp)
                OP_MULT: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                OP_DIV: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quot_s;
                    pend_wr_d = !div_zero;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pend_hi_d = rem_u;
                    pend_lo_d = quot_u;
                    pend_wr_d = !div_zero;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Pending result is only consumed while busy, so it needs no reset
    always_ff @(posedge clk) begin
        pend_hi_q <= pend_hi_d;
        pend_lo_q <= pend_lo_d;
    end

    always_comb begin
        MDUResult = 32'd0;
        if (MDUOp == OP_MFHI) MDUResult = hi_q;
        else if (MDUOp == OP_MFLO) MDUResult = lo_q;
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares Busy and MDUResult.
module tb_mul_div_unit;

    localparam logic [4:0] NONE  = 5'd0;
    localparam logic [4:0] MULT  = 5'd1;
    localparam logic [4:0] MULTU = 5'd2;
    localparam logic [4:0] DIV   = 5'd3;
    localparam logic [4:0] DIVU  = 5'd4;
    localparam logic [4:0] MFHI  = 5'd5;
    localparam logic [4:0] MFLO  = 5'd6;
    localparam logic [4:0] MTHI  = 5'd7;
    localparam logic [4:0] MTLO  = 5'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [4:0]  MDUOp;
    logic [31:0] MDUResult;
    logic        Busy;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
        .MDUResult(MDUResult), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic        busy;
        bit          chk;
        logic [31:0] res;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (Busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy actual %0b required %0b (cycle %0d)", e.name, Busy, e.busy, cyc);
            end
            if (e.chk) begin
                checks++;
                if (MDUResult !== e.res) begin
                    errors++;
                    $display("FAIL %s result actual %08h required %08h (cycle %0d)", e.name, MDUResult, e.res, cyc);
                end
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        MDUOp = op;
        A     = a;
        B     = b;
    endtask

    task automatic expect_c(input string nm, input logic bz, input bit chk, input logic [31:0] r);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.busy = bz;
        e.chk  = chk;
        e.res  = r;
        q.push_back(e);
    endtask

    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        drive(op, a, b);
        expect_c({nm, " start"}, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < n; i++) begin
            drive(NONE, 32'd0, 32'd0);
            expect_c({nm, " busy"}, 1'b1, 1'b0, 32'd0);
        end
    endtask

    task automatic read_hl(input string nm, input logic [31:0] hi, input logic [31:0] lo);
        drive(MFHI, 32'd0, 32'd0);
        expect_c({nm, " HI"}, 1'b0, 1'b1, hi);
        drive(MFLO, 32'd0, 32'd0);
        expect_c({nm, " LO"}, 1'b0, 1'b1, lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        MDUOp = NONE;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        read_hl("reset", 32'd0, 32'd0);

        run_op("mult 100*20", MULT, 32'd100, 32'd20, 5);
        read_hl("mult 100*20", 32'd0, 32'd2000);

        run_op("divu 100/20", DIVU, 32'd100, 32'd20, 10);
        read_hl("divu 100/20", 32'd0, 32'd5);
        run_op("divu 103/20", DIVU, 32'd103, 32'd20, 10);
        read_hl("divu 103/20", 32'd3, 32'd5);

        run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 5);
        read_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult neg", MULT, 32'hFFFF_FFFF, 32'd2, 5);
        read_hl("mult neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 10);
        read_hl("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        read_hl("div ovf", 32'd0, 32'h8000_0000);

        drive(MTHI, 32'h11, 32'd0);
        expect_c("mthi", 1'b0, 1'b0, 32'd0);
        drive(MTLO, 32'h22, 32'd0);
        expect_c("mtlo", 1'b0, 1'b0, 32'd0);
        read_hl("mthi/mtlo", 32'h11, 32'h22);
        run_op("div by 0", DIV, 32'd100, 32'd0, 10);
        read_hl("div by 0", 32'h11, 32'h22);

        // Ops issued while busy, including a start on the completion cycle, must be ignored
        drive(MULT, 32'd3, 32'd4);
        expect_c("busy-ign start", 1'b0, 1'b0, 32'd0);
        drive(MFLO, 32'd0, 32'd0);
        expect_c("busy-ign mflo", 1'b1, 1'b1, 32'h22);
        drive(MTLO, 32'h55, 32'd0);
        expect_c("busy-ign mtlo", 1'b1, 1'b0, 32'd0);
        drive(DIV, 32'd100, 32'd20);
        expect_c("busy-ign div", 1'b1, 1'b0, 32'd0);
        drive(MFHI, 32'd0, 32'd0);
        expect_c("busy-ign mfhi", 1'b1, 1'b1, 32'h11);
        drive(DIVU, 32'd100, 32'd20);
        expect_c("busy-ign last", 1'b1, 1'b0, 32'd0);
        read_hl("busy-ign", 32'd0, 32'd12);

        drive(5'd12, 32'hDEAD_BEEF, 32'd1);
        expect_c("reserved op", 1'b0, 1'b0, 32'd0);
        read_hl("reserved op", 32'd0, 32'd12);

        run_op("rst mid", DIV, 32'd100, 32'd20, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        MDUOp = NONE;
        expect_c("rst mid cycle3", 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        MDUOp = MFLO;
        expect_c("rst cleared LO", 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 12; i++) begin
            drive(NONE, 32'd0, 32'd0);
            expect_c("rst idle", 1'b0, 1'b0, 32'd0);
        end
        read_hl("rst after", 32'd0, 32'd0);

        drive(NONE, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain actual %0d entries required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
